// File: rtl/reveal_flood_ctrl.sv
// rtl/reveal_flood_ctrl.sv - breadth-first flood-fill reveal engine; optional macro REVEAL_CNT_EN
module reveal_flood_ctrl #(
  parameter int X_W         = 5,
  parameter int Y_W         = 4,
  parameter int QUEUE_DEPTH = 64
) (
  input  logic           pixel_clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [X_W-1:0] start_x_i,
  input  logic [Y_W-1:0] start_y_i,
  input  logic [X_W-1:0] field_width_i,
  input  logic [Y_W-1:0] field_height_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           mine_hit_o,
  output logic           overflow_o,
  output logic           mem_req_o,
  output logic           mem_we_o,
  output logic [X_W-1:0] mem_x_o,
  output logic [Y_W-1:0] mem_y_o,
  input  logic           mem_gnt_i,
  input  logic [6:0]     mem_rdata_i,
  output logic [9:0]     revealed_cnt_o
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;
  localparam logic [X_W:0]   ONE_X   = 1;
  localparam logic [Y_W:0]   ONE_Y   = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_RD_REQ, S_RD_WAIT, S_DECIDE, S_WR_REQ, S_EXPAND, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [X_W-1:0] q_x [QUEUE_DEPTH];
  logic [Y_W-1:0] q_y [QUEUE_DEPTH];
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
  logic           q_empty, q_full, push, pop;
  logic [X_W-1:0] push_x;
  logic [Y_W-1:0] push_y;

  logic [X_W-1:0] cur_x_q;
  logic [Y_W-1:0] cur_y_q;
  logic [6:0]     cell_q;
  logic           first_q, mine_q, ovf_q;
  logic [2:0]     nbr_q;

  logic [X_W:0]   lim_x, nb_x;
  logic [Y_W:0]   lim_y, nb_y;
  logic           nb_ok;

  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // A zero field dimension stands for the full 2^W extent (a 16-row field on a 4-bit port)
  assign lim_x = (field_width_i  == '0) ? {1'b1, {X_W{1'b0}}} : {1'b0, field_width_i};
  assign lim_y = (field_height_i == '0) ? {1'b1, {Y_W{1'b0}}} : {1'b0, field_height_i};

  // Neighbour for the current EXPAND step; stepping below zero wraps to all-ones and fails the limit compare
  always_comb begin
    nb_x = {1'b0, cur_x_q};
    nb_y = {1'b0, cur_y_q};
    case (nbr_q)
      3'd0, 3'd3, 3'd5: nb_x = {1'b0, cur_x_q} - ONE_X;
      3'd2, 3'd4, 3'd7: nb_x = {1'b0, cur_x_q} + ONE_X;
      default: ;
    endcase
    case (nbr_q)
      3'd0, 3'd1, 3'd2: nb_y = {1'b0, cur_y_q} - ONE_Y;
      3'd5, 3'd6, 3'd7: nb_y = {1'b0, cur_y_q} + ONE_Y;
      default: ;
    endcase
    nb_ok = (nb_x < lim_x) && (nb_y < lim_y);
  end

  // Next-state logic plus queue push/pop strobes
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    push_x  = nb_x[X_W-1:0];
    push_y  = nb_y[Y_W-1:0];
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          push    = 1'b1;
          push_x  = start_x_i;
          push_y  = start_y_i;
          state_d = S_POP;
        end
      end
      S_POP: begin
        if (q_empty) begin
          state_d = S_DONE;
        end else begin
          pop     = 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ:  if (mem_gnt_i) state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_DECIDE;
      S_DECIDE:  state_d = (cell_q[5] || cell_q[6] || cell_q[4]) ? S_POP : S_WR_REQ;
      S_WR_REQ:  if (mem_gnt_i) state_d = (cell_q[3:0] == 4'd0) ? S_EXPAND : S_POP;
      S_EXPAND: begin
        push = nb_ok && !q_full;
        if (nbr_q == 3'd7) state_d = S_POP;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Queue pointers; the extra MSB tells full from empty
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Queue storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge pixel_clk) begin
    if (push) begin
      q_x[wr_ptr_q[PTR_W-1:0]] <= push_x;
      q_y[wr_ptr_q[PTR_W-1:0]] <= push_y;
    end
  end

  // Per-operation registers: current cell, read data, neighbour index and result flags
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
      cell_q  <= '0;
      nbr_q   <= '0;
      first_q <= 1'b0;
      mine_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        first_q <= 1'b1;
        mine_q  <= 1'b0;
        ovf_q   <= 1'b0;
        nbr_q   <= '0;
      end
      if (pop) begin
        cur_x_q <= q_x[rd_ptr_q[PTR_W-1:0]];
        cur_y_q <= q_y[rd_ptr_q[PTR_W-1:0]];
      end
      if (state_q == S_RD_WAIT) cell_q <= mem_rdata_i;
      if (state_q == S_DECIDE) begin
        if (!cell_q[5] && !cell_q[6] && cell_q[4] && first_q) mine_q <= 1'b1;
        first_q <= 1'b0;
      end
      if (state_q == S_EXPAND) begin
        nbr_q <= nbr_q + 3'd1;
        if (nb_ok && q_full) ovf_q <= 1'b1;
      end
    end
  end

`ifdef REVEAL_CNT_EN
  logic [9:0] cnt_q;

  // Saturating count of cells written by the current operation, held until the next start
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)                                         cnt_q <= '0;
    else if (state_q == S_IDLE && start_i)              cnt_q <= '0;
    else if (state_q == S_WR_REQ && mem_gnt_i && cnt_q != 10'h3ff) cnt_q <= cnt_q + 10'd1;
  end

  assign revealed_cnt_o = cnt_q;
`else
  assign revealed_cnt_o = '0;
`endif

  assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o     = (state_q == S_DONE);
  assign mine_hit_o = (state_q == S_DONE) && mine_q;
  assign overflow_o = ovf_q;
  assign mem_req_o  = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign mem_we_o   = (state_q == S_WR_REQ);
  assign mem_x_o    = cur_x_q;
  assign mem_y_o    = cur_y_q;

endmodule
